// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the SRAM access sequencer:
//   - seqState_t        : sequencer FSM states
//   - DEFAULT_DATA_BASE : byte address of data-memory word 0
//   - HALF_LO / HALF_HI : half-word select for the low/high 16 bits of a word
//   - halfAddr()        : byte address -> SRAM half-word address (untruncated)
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } seqState_t;

    localparam logic [31:0] DEFAULT_DATA_BASE = 32'd1024;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // Each 32-bit word occupies two consecutive SRAM half-words, low half
    // first. The caller truncates the result to its SRAM address width,
    // which gives the intended wrap-around for addresses below the base.
    function automatic logic [31:0] halfAddr(input logic [31:0] byteAddr,
                                             input logic [31:0] base,
                                             input logic        half);
        logic [31:0] word;
        word = (byteAddr - base) >> 2;
        return (word << 1) | {31'b0, half};
    endfunction

endpackage

// File: rtl/sram_access_sequencer_if.sv
// -----------------------------------------------------------------------------
// sram_access_sequencer_if
// MEM-stage side of the SRAM access sequencer.
//   rd_en, wr_en  : load/store request, held high while the pipeline is frozen
//   addr          : byte address of the access
//   write_data    : store value
//   read_data     : load result, valid while ready=1 in DONE
//   ready         : 0 = freeze the pipeline
// Modports: master = MEM stage, slave = sequencer.
// -----------------------------------------------------------------------------
interface sram_access_sequencer_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, addr, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, addr, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_read_cache.sv
// -----------------------------------------------------------------------------
// sram_read_cache
// Single-entry cache of the most recently read word, used by the sequencer
// only when SRAM_READ_CACHE_EN is defined.
// Ports:
//   clk, rst       : clock, synchronous active-low reset (clears valid)
//   lookupAddr_i   : low half-word address of the requested word
//   hit_o          : entry valid and tag matches lookupAddr_i
//   hitData_o      : cached word
//   fillEn_i       : a read completed; replace the entry
//   updEn_i        : a write completed; refresh the entry if it matches
//   entryAddr_i    : low half-word address for fill/update
//   entryData_i    : word for fill/update
// -----------------------------------------------------------------------------
module sram_read_cache #(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookupAddr_i,
    output logic              hit_o,
    output logic [31:0]       hitData_o,
    input  logic              fillEn_i,
    input  logic              updEn_i,
    input  logic [ADDR_W-1:0] entryAddr_i,
    input  logic [31:0]       entryData_i
);

    logic              validQ;
    logic [ADDR_W-1:0] tagQ;
    logic [31:0]       dataQ;

    // Fill always replaces the entry; a write only refreshes data when it
    // targets the cached word, so the entry never goes stale.
    always_ff @(posedge clk) begin
        if (!rst) begin
            validQ <= 1'b0;
            tagQ   <= '0;
            dataQ  <= '0;
        end else if (fillEn_i) begin
            validQ <= 1'b1;
            tagQ   <= entryAddr_i;
            dataQ  <= entryData_i;
        end else if (updEn_i && validQ && (tagQ == entryAddr_i)) begin
            dataQ  <= entryData_i;
        end
    end

    assign hit_o     = validQ && (tagQ == lookupAddr_i);
    assign hitData_o = dataQ;

endmodule

// File: rtl/sram_access_sequencer.sv
// -----------------------------------------------------------------------------
// sram_access_sequencer
// Turns 32-bit MEM-stage loads/stores into two 16-bit SRAM accesses (low
// half-word, then high half-word), each phase held WAIT_CYCLES cycles.
// Optional feature macro: SRAM_READ_CACHE_EN (single-entry read cache).
// Ports:
//   clk        : system clock
//   rst        : synchronous active-low reset
//   bus        : MEM-stage request interface (slave modport)
//   SRAM_DQ    : 16-bit bidirectional SRAM data bus
//   SRAM_ADDR  : registered SRAM half-word address
//   SRAM_LB_N, SRAM_UB_N, SRAM_CE_N : tied active (0)
//   SRAM_WE_N  : write enable, active low
//   SRAM_OE_N  : output enable, active low
// -----------------------------------------------------------------------------
module sram_access_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE,
    parameter int          ADDR_W      = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_access_sequencer_if.slave bus,
    inout  wire  [15:0]           SRAM_DQ,
    output logic [ADDR_W-1:0]     SRAM_ADDR,
    output logic                  SRAM_LB_N,
    output logic                  SRAM_UB_N,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N
);

    localparam logic [3:0] PHASE_LAST = 4'(WAIT_CYCLES - 1);
    // With a one-cycle phase the only cycle is also the hold cycle.
    localparam logic WE_N_AT_ENTRY = (WAIT_CYCLES == 1);

    seqState_t         stateQ;
    logic [3:0]        cntQ;
    logic [ADDR_W-1:0] sramAddrQ;
    logic [15:0]       loHalfQ;
    logic [31:0]       readDataQ;
    logic [31:0]       wrDataQ;
    logic [15:0]       dqOutQ;
    logic              dqOeQ;
    logic              weNQ;
    logic              oeNQ;
    logic [ADDR_W-1:0] reqLoAddr;

    assign reqLoAddr = ADDR_W'(halfAddr(bus.addr, DATA_BASE, HALF_LO));

`ifdef SRAM_READ_CACHE_EN
    logic        cacheHit;
    logic [31:0] cacheData;
    logic        cacheFill;
    logic        cacheUpd;
    logic [31:0] cacheEntryData;

    // Entries are filled/updated on the final cycle of the high phase, when
    // the whole word is known.
    assign cacheFill      = (stateQ == ST_RD_HI) && (cntQ == 4'd0);
    assign cacheUpd       = (stateQ == ST_WR_HI) && (cntQ == 4'd0);
    assign cacheEntryData = (stateQ == ST_RD_HI) ? {SRAM_DQ, loHalfQ} : wrDataQ;

    sram_read_cache #(
        .ADDR_W (ADDR_W)
    ) uReadCache (
        .clk          (clk),
        .rst          (rst),
        .lookupAddr_i (reqLoAddr),
        .hit_o        (cacheHit),
        .hitData_o    (cacheData),
        .fillEn_i     (cacheFill),
        .updEn_i      (cacheUpd),
        .entryAddr_i  ({sramAddrQ[ADDR_W-1:1], HALF_LO}),
        .entryData_i  (cacheEntryData)
    );
`endif

    // Sequencer FSM with all SRAM controls registered. Request inputs are
    // only looked at in IDLE; the store value is captured there so later
    // changes on the MEM side cannot corrupt an access in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ    <= ST_IDLE;
            cntQ      <= '0;
            sramAddrQ <= '0;
            loHalfQ   <= '0;
            readDataQ <= '0;
            wrDataQ   <= '0;
            dqOutQ    <= '0;
            dqOeQ     <= 1'b0;
            weNQ      <= 1'b1;
            oeNQ      <= 1'b1;
        end else begin
            unique case (stateQ)
                ST_IDLE: begin
                    if (bus.wr_en) begin
                        stateQ    <= ST_WR_LO;
                        cntQ      <= PHASE_LAST;
                        sramAddrQ <= reqLoAddr;
                        wrDataQ   <= bus.write_data;
                        dqOutQ    <= bus.write_data[15:0];
                        dqOeQ     <= 1'b1;
                        weNQ      <= WE_N_AT_ENTRY;
                    end else if (bus.rd_en) begin
`ifdef SRAM_READ_CACHE_EN
                        if (cacheHit) begin
                            stateQ    <= ST_DONE;
                            readDataQ <= cacheData;
                        end else
`endif
                        begin
                            stateQ    <= ST_RD_LO;
                            cntQ      <= PHASE_LAST;
                            sramAddrQ <= reqLoAddr;
                            oeNQ      <= 1'b0;
                        end
                    end
                end

                ST_RD_LO: begin
                    if (cntQ == 4'd0) begin
                        loHalfQ   <= SRAM_DQ;
                        stateQ    <= ST_RD_HI;
                        cntQ      <= PHASE_LAST;
                        sramAddrQ <= {sramAddrQ[ADDR_W-1:1], HALF_HI};
                    end else begin
                        cntQ <= cntQ - 4'd1;
                    end
                end

                // read_data is only committed here so it holds the previous
                // load's value for the whole duration of this read.
                ST_RD_HI: begin
                    if (cntQ == 4'd0) begin
                        readDataQ <= {SRAM_DQ, loHalfQ};
                        stateQ    <= ST_DONE;
                        oeNQ      <= 1'b1;
                    end else begin
                        cntQ <= cntQ - 4'd1;
                    end
                end

                // WE_N rises one cycle before the phase ends while data and
                // address stay put, giving the SRAM its hold time.
                ST_WR_LO: begin
                    if (cntQ == 4'd0) begin
                        stateQ    <= ST_WR_HI;
                        cntQ      <= PHASE_LAST;
                        sramAddrQ <= {sramAddrQ[ADDR_W-1:1], HALF_HI};
                        dqOutQ    <= wrDataQ[31:16];
                        weNQ      <= WE_N_AT_ENTRY;
                    end else begin
                        cntQ <= cntQ - 4'd1;
                        if (cntQ == 4'd1) begin
                            weNQ <= 1'b1;
                        end
                    end
                end

                ST_WR_HI: begin
                    if (cntQ == 4'd0) begin
                        stateQ <= ST_DONE;
                        dqOeQ  <= 1'b0;
                        weNQ   <= 1'b1;
                    end else begin
                        cntQ <= cntQ - 4'd1;
                        if (cntQ == 4'd1) begin
                            weNQ <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    stateQ <= ST_IDLE;
                end

                default: begin
                    stateQ <= ST_IDLE;
                    dqOeQ  <= 1'b0;
                    weNQ   <= 1'b1;
                    oeNQ   <= 1'b1;
                end
            endcase
        end
    end

    // ready drops in the same IDLE cycle a request appears, so the pipeline
    // freezes before it can advance past the load/store.
    assign bus.ready = ((stateQ == ST_IDLE) && !bus.rd_en && !bus.wr_en)
                       || (stateQ == ST_DONE);
    assign bus.read_data = readDataQ;

    assign SRAM_DQ   = dqOeQ ? dqOutQ : 16'bz;
    assign SRAM_ADDR = sramAddrQ;
    assign SRAM_WE_N = weNQ;
    assign SRAM_OE_N = oeNQ;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

endmodule
